// File: rtl/snn_frame_loader.sv
// snn_frame_loader: unpacks received bytes LSB-first into a 1-bit-wide input
// memory and issues one start pulse per complete frame once the core is idle.
// It also resyncs on inter-byte timeout, detects overruns, reports errors and
// counts started frames.
module snn_frame_loader #(
    parameter int N_BITS        = 784,
    parameter int BITS_PER_BYTE = 8,
    parameter int TIMEOUT_CYC   = 500000,
    parameter int ADDR_W        = $clog2(N_BITS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              byte_vld,
    input  logic [7:0]        byte_data,
    input  logic              core_busy,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wdata,
    output logic              frame_start,
    output logic              frame_err,
    output logic [1:0]        err_code,
    output logic [7:0]        frame_cnt
);

    // The pointer is one bit wider than the address so N_BITS is reachable.
    localparam int PTR_W = ADDR_W + 1;
    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [PTR_W-1:0] PTR_FULL = PTR_W'(N_BITS);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [2:0]       IDX_LAST = 3'(BITS_PER_BYTE - 1);

    localparam logic [1:0] ERR_TIMEOUT = 2'b01;
    localparam logic [1:0] ERR_OVERRUN = 2'b10;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        UNPACK = 3'd1,
        GAP    = 3'd2,
        HOLD   = 3'd3,
        FIRE   = 3'd4
    } state_t;

    state_t           state_reg, state_next;
    logic [PTR_W-1:0] ptr_reg, ptr_next;
    logic [PTR_W-1:0] ptr_inc;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [2:0]       idx_reg, idx_next;
    logic [7:0]       byte_reg, byte_next;
    logic             err_reg, err_next;
    logic [1:0]       code_reg, code_next;
    logic [7:0]       fcnt_reg, fcnt_next;

    assign ptr_inc = ptr_reg + PTR_W'(1);

    // State and datapath registers; reset discards any partial frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            ptr_reg   <= '0;
            cnt_reg   <= '0;
            idx_reg   <= '0;
            byte_reg  <= '0;
            err_reg   <= 1'b0;
            code_reg  <= 2'b00;
            fcnt_reg  <= 8'd0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            cnt_reg   <= cnt_next;
            idx_reg   <= idx_next;
            byte_reg  <= byte_next;
            err_reg   <= err_next;
            code_reg  <= code_next;
            fcnt_reg  <= fcnt_next;
        end
    end

    // Next-state and datapath update logic.
    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        cnt_next   = cnt_reg;
        idx_next   = idx_reg;
        byte_next  = byte_reg;
        err_next   = 1'b0;
        code_next  = code_reg;
        fcnt_next  = fcnt_reg;
        case (state_reg)
            IDLE: begin
                if (byte_vld) begin
                    byte_next  = byte_data;
                    idx_next   = 3'd0;
                    state_next = UNPACK;
                end
            end
            UNPACK: begin
                if (byte_vld) begin
                    // Overrun mid-byte: abort the frame and drop the new byte.
                    err_next   = 1'b1;
                    code_next  = ERR_OVERRUN;
                    ptr_next   = '0;
                    state_next = IDLE;
                end else begin
                    ptr_next = ptr_inc;
                    if (ptr_inc == PTR_FULL) begin
                        // Frame complete; leftover bits of this byte are ignored.
                        state_next = HOLD;
                    end else if (idx_reg == IDX_LAST) begin
                        cnt_next   = '0;
                        state_next = GAP;
                    end else begin
                        idx_next = idx_reg + 3'd1;
                    end
                end
            end
            GAP: begin
                if (byte_vld) begin
                    // A byte arriving on the expiry cycle still wins.
                    cnt_next   = '0;
                    byte_next  = byte_data;
                    idx_next   = 3'd0;
                    state_next = UNPACK;
                end else if (cnt_reg == CNT_MAX) begin
                    err_next   = 1'b1;
                    code_next  = ERR_TIMEOUT;
                    ptr_next   = '0;
                    cnt_next   = '0;
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            HOLD: begin
                // A completed frame is kept; a stray byte is only reported.
                if (byte_vld) begin
                    err_next  = 1'b1;
                    code_next = ERR_OVERRUN;
                end
                if (!core_busy) begin
                    state_next = FIRE;
                end
            end
            FIRE: begin
                if (byte_vld) begin
                    err_next  = 1'b1;
                    code_next = ERR_OVERRUN;
                end
                fcnt_next  = fcnt_reg + 8'd1;
                ptr_next   = '0;
                state_next = IDLE;
            end
            default: begin
                ptr_next   = '0;
                state_next = IDLE;
            end
        endcase
    end

    // Outputs decode registered state only, so no input reaches an output combinationally.
    always_comb begin
        mem_we      = (state_reg == UNPACK);
        mem_addr    = ptr_reg[ADDR_W-1:0];
        mem_wdata   = mem_we & byte_reg[idx_reg];
        frame_start = (state_reg == FIRE);
        frame_err   = err_reg;
        err_code    = code_reg;
        frame_cnt   = fcnt_reg;
    end

endmodule

// File: tb/tb_snn_frame_loader.sv
// Directed bench for snn_frame_loader: a 784-bit instance (timeout 100) and
// a 12-bit instance for partial-byte and frame-counter wrap checks.
module tb_snn_frame_loader;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // 784-bit instance
    logic       a_vld, a_busy, a_we, a_wdata, a_start, a_err;
    logic [7:0] a_data, a_cnt;
    logic [9:0] a_addr;
    logic [1:0] a_code;

    // 12-bit instance
    logic       b_vld, b_busy, b_we, b_wdata, b_start, b_err;
    logic [7:0] b_data, b_cnt;
    logic [3:0] b_addr;
    logic [1:0] b_code;

    snn_frame_loader #(.N_BITS(784), .BITS_PER_BYTE(8), .TIMEOUT_CYC(100)) dut_a (
        .clk(clk), .rst(rst), .byte_vld(a_vld), .byte_data(a_data), .core_busy(a_busy),
        .mem_we(a_we), .mem_addr(a_addr), .mem_wdata(a_wdata), .frame_start(a_start),
        .frame_err(a_err), .err_code(a_code), .frame_cnt(a_cnt)
    );

    snn_frame_loader #(.N_BITS(12), .BITS_PER_BYTE(8), .TIMEOUT_CYC(100)) dut_b (
        .clk(clk), .rst(rst), .byte_vld(b_vld), .byte_data(b_data), .core_busy(b_busy),
        .mem_we(b_we), .mem_addr(b_addr), .mem_wdata(b_wdata), .frame_start(b_start),
        .frame_err(b_err), .err_code(b_code), .frame_cnt(b_cnt)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Observation counters, updated only by tick().
    logic [7:0] pat = 8'hA5;
    int a_wr = 0, a_bad_data = 0, a_bad_seq = 0, a_next_addr = 0, a_last_addr = 0;
    int a_starts = 0, a_errs = 0, a_start_t = 0, a_err_t = 0, a_we_t = 0;
    int b_wr = 0, b_bad_data = 0, b_bad_seq = 0, b_next_addr = 0, b_last_addr = 0;
    int b_starts = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    // Advance one cycle and sample outputs at the falling edge.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (a_we) begin
            a_wr++;
            a_we_t = cyc;
            a_last_addr = int'(a_addr);
            if (a_wdata != pat[a_addr[2:0]]) a_bad_data++;
            if (int'(a_addr) != a_next_addr) a_bad_seq++;
            a_next_addr = int'(a_addr) + 1;
        end
        if (a_start) begin a_starts++; a_start_t = cyc; end
        if (a_err)   begin a_errs++;   a_err_t   = cyc; end
        if (b_we) begin
            b_wr++;
            b_last_addr = int'(b_addr);
            if (b_wdata != 1'b1) b_bad_data++;
            if (int'(b_addr) != b_next_addr || b_addr >= 4'd12) b_bad_seq++;
            b_next_addr = int'(b_addr) + 1;
        end
        if (b_start) b_starts++;
    endtask

    task automatic send_a(input logic [7:0] d, input int gap);
        a_vld = 1'b1; a_data = d;
        tick();
        a_vld = 1'b0;
        repeat (gap - 1) tick();
    endtask

    task automatic send_b(input logic [7:0] d, input int gap);
        b_vld = 1'b1; b_data = d;
        tick();
        b_vld = 1'b0;
        repeat (gap - 1) tick();
    endtask

    task automatic frame_a();
        a_next_addr = 0;
        for (int i = 0; i < 98; i++) send_a(8'hA5, 20);
    endtask

    task automatic frame_b();
        b_next_addr = 0;
        send_b(8'hFF, 10);
        send_b(8'h0F, 10);
    endtask

    int w0, s0, e0, t0, rel;

    initial begin
        rst = 1'b1;
        a_vld = 1'b0; a_data = 8'h00; a_busy = 1'b0;
        b_vld = 1'b0; b_data = 8'h00; b_busy = 1'b0;
        repeat (3) tick();
        // Reset state
        check_eq("rst_we",    int'(a_we), 0);
        check_eq("rst_addr",  int'(a_addr), 0);
        check_eq("rst_start", int'(a_start), 0);
        check_eq("rst_err",   int'(a_err), 0);
        check_eq("rst_code",  int'(a_code), 0);
        check_eq("rst_cnt",   int'(a_cnt), 0);
        rst = 1'b0;
        tick();

        // 1: full frame of 0xA5, core idle
        w0 = a_wr; s0 = a_starts; e0 = a_errs;
        frame_a();
        repeat (10) tick();
        check_eq("t1_writes",    a_wr - w0, 784);
        check_eq("t1_data_bad",  a_bad_data, 0);
        check_eq("t1_seq_bad",   a_bad_seq, 0);
        check_eq("t1_last_addr", a_last_addr, 783);
        check_eq("t1_starts",    a_starts - s0, 1);
        check_eq("t1_start_lat", a_start_t - a_we_t, 2);
        check_eq("t1_errs",      a_errs - e0, 0);
        check_eq("t1_cnt",       int'(a_cnt), 1);

        // 2: 10 bytes then silence; error is the registered pulse after the 100th gap cycle
        w0 = a_wr; s0 = a_starts; e0 = a_errs;
        a_next_addr = 0;
        for (int i = 0; i < 10; i++) send_a(8'hA5, 20);
        repeat (120) tick();
        check_eq("t2_writes",   a_wr - w0, 80);
        check_eq("t2_errs",     a_errs - e0, 1);
        check_eq("t2_err_time", a_err_t - a_we_t, 101);
        check_eq("t2_code",     int'(a_code), 1);
        check_eq("t2_starts",   a_starts - s0, 0);
        s0 = a_starts;
        frame_a();
        repeat (5) tick();
        check_eq("t2_resync_seq", a_bad_seq, 0);
        check_eq("t2_resync_start", a_starts - s0, 1);
        check_eq("t2_cnt", int'(a_cnt), 2);

        // 3: second byte 3 cycles after the first aborts the frame
        w0 = a_wr; e0 = a_errs;
        a_next_addr = 0;
        t0 = cyc;
        a_vld = 1'b1; a_data = 8'hA5;
        tick();
        a_vld = 1'b0;
        tick(); tick();
        a_vld = 1'b1; a_data = 8'h3C;
        tick();
        a_vld = 1'b0;
        repeat (20) tick();
        check_eq("t3_writes",   a_wr - w0, 3);
        check_eq("t3_errs",     a_errs - e0, 1);
        check_eq("t3_err_time", a_err_t - t0, 4);
        check_eq("t3_code",     int'(a_code), 2);
        s0 = a_starts;
        frame_a();
        repeat (5) tick();
        check_eq("t3_resync_seq", a_bad_seq, 0);
        check_eq("t3_data_bad",   a_bad_data, 0);
        check_eq("t3_starts",     a_starts - s0, 1);
        check_eq("t3_cnt",        int'(a_cnt), 3);

        // 4: core busy holds the start; extra byte in HOLD is an overrun
        a_busy = 1'b1;
        w0 = a_wr; s0 = a_starts; e0 = a_errs;
        frame_a();
        send_a(8'h00, 5);
        check_eq("t4_held", a_starts - s0, 0);
        for (int i = 0; i < 200 && cyc < a_we_t + 50; i++) tick();
        rel = cyc;
        check_eq("t4_release_at", rel - a_we_t, 50);
        a_busy = 1'b0;
        repeat (5) tick();
        check_eq("t4_writes",     a_wr - w0, 784);
        check_eq("t4_starts",     a_starts - s0, 1);
        check_eq("t4_start_time", a_start_t - rel, 1);
        check_eq("t4_errs",       a_errs - e0, 1);
        check_eq("t4_code",       int'(a_code), 2);
        check_eq("t4_cnt",        int'(a_cnt), 4);

        // 6: reset at bit 400 discards the partial frame
        s0 = a_starts;
        a_next_addr = 0;
        for (int i = 0; i < 50; i++) send_a(8'hA5, 20);
        a_vld = 1'b1; a_data = 8'hA5;
        tick();
        a_vld = 1'b0;
        tick();
        check_eq("t6_addr_before_rst", a_last_addr, 401);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("t6_we",    int'(a_we), 0);
        check_eq("t6_addr",  int'(a_addr), 0);
        check_eq("t6_wdata", int'(a_wdata), 0);
        check_eq("t6_start", int'(a_start), 0);
        check_eq("t6_err",   int'(a_err), 0);
        check_eq("t6_code",  int'(a_code), 0);
        check_eq("t6_cnt",   int'(a_cnt), 0);
        e0 = a_errs;
        repeat (150) tick();
        check_eq("t6_no_start", a_starts - s0, 0);
        check_eq("t6_no_err",   a_errs - e0, 0);
        frame_a();
        repeat (5) tick();
        check_eq("t6_seq",    a_bad_seq, 0);
        check_eq("t6_starts", a_starts - s0, 1);
        check_eq("t6_cnt",    int'(a_cnt), 1);

        // 5: 12-bit frame from 0xFF, 0x0F; upper nibble of the second byte ignored
        w0 = b_wr; s0 = b_starts;
        frame_b();
        repeat (5) tick();
        check_eq("t5_writes",    b_wr - w0, 12);
        check_eq("t5_data_bad",  b_bad_data, 0);
        check_eq("t5_seq_bad",   b_bad_seq, 0);
        check_eq("t5_last_addr", b_last_addr, 11);
        check_eq("t5_starts",    b_starts - s0, 1);
        check_eq("t5_cnt",       int'(b_cnt), 1);

        // Frame counter wrap 255 -> 0
        for (int i = 0; i < 254; i++) frame_b();
        check_eq("wrap_cnt_255", int'(b_cnt), 255);
        frame_b();
        repeat (3) tick();
        check_eq("wrap_cnt_0",    int'(b_cnt), 0);
        check_eq("wrap_starts",   b_starts - s0, 256);
        check_eq("wrap_seq_bad",  b_bad_seq, 0);
        check_eq("wrap_data_bad", b_bad_data, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
